traffic_light_fsm: RTL and testbench
====================================

// Module: traffic_light_fsm
// PURPOSE
//  Main-street / side-street traffic light sequencer with pedestrian walk phase.
//  Sits directly upstream of Timer: on each state entry, drives start_timer and a 4-bit interval value.
//  Consumes Timer's one-cycle expired pulse to advance.
//  Drives the lamp outputs for both streets and the walk lamp.
// PARAMETERS
//  T_BASE  6  base green interval, seconds (legal 1..15; 0 illegal, Timer wraps)
//  T_EXT   3  green extension interval and walk interval, seconds (1..15)
//  T_YEL   2  yellow interval, seconds (1..15)
// PORTS
//  clk           in   1  system clock; all state on posedge
//  Reset_Sync    in   1  reset, asynchronous, active-high
//  Sensor        in   1  side-street vehicle present (level; pre-synchronised)
//  Walk_Request  in   1  pedestrian button (level/pulse; pre-synchronised)
//  expired       in   1  from Timer: one-cycle pulse at end of interval
//  start_timer   out  1  to Timer: one-cycle pulse, (re)starts interval
//  value         out  4  to Timer: interval length for current state
//  Main_Light    out  3  {R,Y,G} main street
//  Side_Light    out  3  {R,Y,G} side street
//  Walk_Light    out  1  pedestrian walk lamp
// BEHAVIOUR
//  - Moore FSM. All outputs are registered and updated on the same edge as state.
//  - Reset (async) values: state=MAIN_G, start_timer=1 (holds Timer cleared), value=T_BASE,
//    Main_Light=001, Side_Light=100, Walk_Light=0, walk_reg=0.
//    start_timer drops to 0 on the first clk edge after release; this counts as the MAIN_G entry pulse.
//  - State entry handshake:
//    - Every transition, including re-entry of the same state, sets start_timer=1 for exactly one cycle.
//    - value is set to the new state's interval on that edge and held stable until the next transition.
//  - expired is sampled only when start_timer==0. An expired coincident with start_timer=1 is ignored.
//  - States / interval / lamps (Main,Side,Walk) / exit on expired:
//    MAIN_G   T_BASE 001,100,0  Sensor -> MAIN_GX; else walk_reg -> MAIN_Y; else re-enter MAIN_G
//    MAIN_GX  T_EXT  001,100,0  -> MAIN_Y
//    MAIN_Y   T_YEL  010,100,0  walk_reg -> WALK; else -> SIDE_G
//    WALK     T_EXT  100,100,1  -> SIDE_G
//    SIDE_G   T_BASE 100,001,0  Sensor -> SIDE_GX; else -> SIDE_Y
//    SIDE_GX  T_EXT  100,001,0  -> SIDE_Y
//    SIDE_Y   T_YEL  100,010,0  -> MAIN_G
//  - Sensor is sampled only on the expired cycle. No mid-interval change of path.
//  - walk_reg:
//    - Set on any cycle with Walk_Request=1.
//    - Cleared on the edge that enters WALK. A Walk_Request on that same edge is dropped (it is being served).
//    - A request during WALK or later is held for the next cycle round.
//  - Safety invariant: at least one of Main_Light/Side_Light is 100 in every cycle. Never both non-red.
//  - Illegal state encoding -> MAIN_G with an entry pulse. No lockup.
//  - Async reset mid-interval: immediate return to reset values. No partial lamp combinations.
// STRUCTURE
//  - Shared package traffic_pkg:
//    - State localparams (3-bit, 7 used).
//    - Lamp codes: LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001.
//    - Timer value width = 4.
//  - Sub-module walk_register: set/clear latch for Walk_Request, async reset, clear-wins.
//  - The FSM core stays in this file.
// TESTING  (bench: Timer instance + oneHz_Enable every 4 clk; T_BASE=6,T_EXT=3,T_YEL=2)
//  1. Reset asserted mid-SIDE_G -> same cycle: Main=001, Side=100, start_timer=1, value=6.
//     Release -> start_timer=0 after 1 edge.
//  2. Sensor=0, no walk -> MAIN_G re-entered every expiry.
//     One start_timer pulse per re-entry; lamps never leave 001/100.
//  3. Sensor=1 throughout -> sequence MAIN_G(6)->MAIN_GX(3)->MAIN_Y(2)->SIDE_G(6)->SIDE_GX(3)->SIDE_Y(2)->MAIN_G.
//     value matches each state.
//  4. Walk_Request 1-cycle pulse during MAIN_G, Sensor=0 -> MAIN_Y, then WALK (Walk_Light=1, both 100, value=3),
//     then SIDE_G. walk_reg=0 after WALK entry.
//  5. Walk_Request held high across WALK entry -> walk_reg clears on entry, re-sets the next cycle.
//     WALK recurs in the following round.
//  6. Force expired=1 on a start_timer=1 cycle -> no transition.
//     Assert the safety invariant on every cycle of all tests.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types and constants for the traffic light sequencer:
//                state encodings, lamp codes, timer value width and helpers
//                mapping a state to its lamp pattern and interval.
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    localparam int STATE_W = 3;
    localparam int VALUE_W = 4;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Seven of the eight 3-bit codes are used; the eighth is recovered to MAIN_G.
    localparam logic [STATE_W-1:0] ENC_MAIN_G  = 3'd0;
    localparam logic [STATE_W-1:0] ENC_MAIN_GX = 3'd1;
    localparam logic [STATE_W-1:0] ENC_MAIN_Y  = 3'd2;
    localparam logic [STATE_W-1:0] ENC_WALK    = 3'd3;
    localparam logic [STATE_W-1:0] ENC_SIDE_G  = 3'd4;
    localparam logic [STATE_W-1:0] ENC_SIDE_GX = 3'd5;
    localparam logic [STATE_W-1:0] ENC_SIDE_Y  = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        MAIN_G  = ENC_MAIN_G,
        MAIN_GX = ENC_MAIN_GX,
        MAIN_Y  = ENC_MAIN_Y,
        WALK    = ENC_WALK,
        SIDE_G  = ENC_SIDE_G,
        SIDE_GX = ENC_SIDE_GX,
        SIDE_Y  = ENC_SIDE_Y
    } state_t;

    typedef struct packed {
        logic [2:0] main_lamp;
        logic [2:0] side_lamp;
        logic       walk_lamp;
    } lamps_t;

    // Lamp pattern shown while in a given state; anything unknown shows MAIN_G.
    function automatic lamps_t state_lamps(input state_t s);
        lamps_t l;
        case (s)
            MAIN_G:  l = {LAMP_G, LAMP_R, 1'b0};
            MAIN_GX: l = {LAMP_G, LAMP_R, 1'b0};
            MAIN_Y:  l = {LAMP_Y, LAMP_R, 1'b0};
            WALK:    l = {LAMP_R, LAMP_R, 1'b1};
            SIDE_G:  l = {LAMP_R, LAMP_G, 1'b0};
            SIDE_GX: l = {LAMP_R, LAMP_G, 1'b0};
            SIDE_Y:  l = {LAMP_R, LAMP_Y, 1'b0};
            default: l = {LAMP_G, LAMP_R, 1'b0};
        endcase
        return l;
    endfunction

    // Timer interval loaded on entry to a given state.
    function automatic logic [VALUE_W-1:0] state_interval(
        input state_t             s,
        input logic [VALUE_W-1:0] t_base,
        input logic [VALUE_W-1:0] t_ext,
        input logic [VALUE_W-1:0] t_yel
    );
        logic [VALUE_W-1:0] v;
        case (s)
            MAIN_G:  v = t_base;
            MAIN_GX: v = t_ext;
            MAIN_Y:  v = t_yel;
            WALK:    v = t_ext;
            SIDE_G:  v = t_base;
            SIDE_GX: v = t_ext;
            SIDE_Y:  v = t_yel;
            default: v = t_base;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/walk_register.sv
`default_nettype none
// ============================================================================
//  Module      : walk_register
//  Description : Pending pedestrian request flag. Set by the walk button,
//                cleared when the walk phase is entered; clear has priority.
//  Revision    : 1.0  initial release
// ============================================================================
module walk_register (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clear,
    output logic q
);

    // Remember a request until it is served; a request on the serving edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (clear) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_fsm
//  Description : Main/side street traffic light sequencer with pedestrian walk
//                phase. Moore machine with registered lamps; on every state
//                entry it pulses start_timer and presents the new interval on
//                value, and it advances on the timer's expired pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2
) (
    input  logic               clk,
    input  logic               Reset_Sync,
    input  logic               Sensor,
    input  logic               Walk_Request,
    input  logic               expired,
    output logic               start_timer,
    output logic [VALUE_W-1:0] value,
    output logic [2:0]         Main_Light,
    output logic [2:0]         Side_Light,
    output logic               Walk_Light
);

    localparam logic [VALUE_W-1:0] V_BASE = VALUE_W'(T_BASE);
    localparam logic [VALUE_W-1:0] V_EXT  = VALUE_W'(T_EXT);
    localparam logic [VALUE_W-1:0] V_YEL  = VALUE_W'(T_YEL);

    state_t             state;
    state_t             next_state;
    logic               transition;
    logic               accept;
    logic               enter_walk;
    logic               walk_reg;
    lamps_t             next_lamps;
    logic [VALUE_W-1:0] next_value;

    // The timer is being restarted while start_timer is high, so an expiry then is stale.
    assign accept     = ~start_timer & expired;
    assign next_lamps = state_lamps(next_state);
    assign next_value = state_interval(next_state, V_BASE, V_EXT, V_YEL);
    assign enter_walk = transition & (next_state == WALK);

    walk_register u_walk_register (
        .clk   (clk),
        .rst   (Reset_Sync),
        .set   (Walk_Request),
        .clear (enter_walk),
        .q     (walk_reg)
    );

    // Exit decision for the current state; Sensor and walk_reg only matter on an accepted expiry.
    always_comb begin
        next_state = state;
        transition = 1'b0;
        case (state)
            MAIN_G: begin
                if (accept) begin
                    transition = 1'b1;
                    if (Sensor) begin
                        next_state = MAIN_GX;
                    end else if (walk_reg) begin
                        next_state = MAIN_Y;
                    end else begin
                        next_state = MAIN_G;
                    end
                end
            end
            MAIN_GX: begin
                if (accept) begin
                    transition = 1'b1;
                    next_state = MAIN_Y;
                end
            end
            MAIN_Y: begin
                if (accept) begin
                    transition = 1'b1;
                    next_state = walk_reg ? WALK : SIDE_G;
                end
            end
            WALK: begin
                if (accept) begin
                    transition = 1'b1;
                    next_state = SIDE_G;
                end
            end
            SIDE_G: begin
                if (accept) begin
                    transition = 1'b1;
                    next_state = Sensor ? SIDE_GX : SIDE_Y;
                end
            end
            SIDE_GX: begin
                if (accept) begin
                    transition = 1'b1;
                    next_state = SIDE_Y;
                end
            end
            SIDE_Y: begin
                if (accept) begin
                    transition = 1'b1;
                    next_state = MAIN_G;
                end
            end
            default: begin
                // Unused encoding: recover to MAIN_G with a fresh entry pulse.
                transition = 1'b1;
                next_state = MAIN_G;
            end
        endcase
    end

    // State and all outputs move together so lamps never show a mixed pattern.
    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            state       <= MAIN_G;
            start_timer <= 1'b1;
            value       <= V_BASE;
            Main_Light  <= LAMP_G;
            Side_Light  <= LAMP_R;
            Walk_Light  <= 1'b0;
        end else begin
            start_timer <= transition;
            if (transition) begin
                state      <= next_state;
                value      <= next_value;
                Main_Light <= next_lamps.main_lamp;
                Side_Light <= next_lamps.side_lamp;
                Walk_Light <= next_lamps.walk_lamp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_fsm
//  Description : Self-checking bench for traffic_light_fsm with a behavioural
//                Timer (one tick every 4 clocks) and a phase-table model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_light_fsm;

    localparam int T_BASE = 6;
    localparam int T_EXT  = 3;
    localparam int T_YEL  = 2;

    localparam int P_MG  = 0;
    localparam int P_MGX = 1;
    localparam int P_MY  = 2;
    localparam int P_WK  = 3;
    localparam int P_SG  = 4;
    localparam int P_SGX = 5;
    localparam int P_SY  = 6;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // Phase table: interval and lamps per phase.
    int         ph_len  [7] = '{T_BASE, T_EXT, T_YEL, T_EXT, T_BASE, T_EXT, T_YEL};
    logic [2:0] ph_main [7] = '{G, G, Y, R, R, R, R};
    logic [2:0] ph_side [7] = '{R, R, R, R, G, G, Y};
    logic       ph_walk [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic [3:0] v;
        int         ph;
    } exp_t;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       sensor    = 1'b0;
    logic       walk_req  = 1'b0;
    logic       force_exp = 1'b0;
    logic       tmr_exp   = 1'b0;
    logic       expired;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk_l;

    int checks       = 0;
    int errors       = 0;
    int walk_entries = 0;

    exp_t q[$];
    exp_t cur;
    int   m_ph    = P_MG;
    bit   m_start = 1'b1;
    bit   m_walk  = 1'b0;
    bit   m_enter_walk;
    int   m_next;

    int unsigned t_cnt = 0;
    int          t_pre = 0;

    assign expired = tmr_exp | force_exp;

    traffic_light_fsm #(
        .T_BASE (T_BASE),
        .T_EXT  (T_EXT),
        .T_YEL  (T_YEL)
    ) dut (
        .clk          (clk),
        .Reset_Sync   (rst),
        .Sensor       (sensor),
        .Walk_Request (walk_req),
        .expired      (expired),
        .start_timer  (start_timer),
        .value        (value),
        .Main_Light   (main_l),
        .Side_Light   (side_l),
        .Walk_Light   (walk_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int n);
        exp_t e;
        e.m  = ph_main[n];
        e.s  = ph_side[n];
        e.w  = ph_walk[n];
        e.v  = 4'(ph_len[n]);
        e.ph = n;
        return e;
    endfunction

    // Exit rules written straight from the phase description.
    function automatic int next_phase(input int ph, input bit sens, input bit wk);
        case (ph)
            P_MG:    return sens ? P_MGX : (wk ? P_MY : P_MG);
            P_MGX:   return P_MY;
            P_MY:    return wk ? P_WK : P_SG;
            P_WK:    return P_SG;
            P_SG:    return sens ? P_SGX : P_SY;
            P_SGX:   return P_SY;
            default: return P_MG;
        endcase
    endfunction

    // Behavioural Timer: loads on start_timer, ticks every 4 clocks, pulses at zero.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_cnt   <= 0;
            t_pre   <= 0;
            tmr_exp <= 1'b0;
        end else if (start_timer) begin
            t_cnt   <= value;
            t_pre   <= 0;
            tmr_exp <= 1'b0;
        end else begin
            tmr_exp <= 1'b0;
            if (t_cnt != 0) begin
                if (t_pre == 3) begin
                    t_pre <= 0;
                    t_cnt <= t_cnt - 1;
                    if (t_cnt == 1) tmr_exp <= 1'b1;
                end else begin
                    t_pre <= t_pre + 1;
                end
            end
        end
    end

    // Reference model: pushes the expected entry whenever a phase change is due.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph    = P_MG;
            m_start = 1'b1;
            m_walk  = 1'b0;
            q.delete();
            q.push_back(mk(P_MG));
        end else begin
            m_enter_walk = 1'b0;
            if (!m_start && expired) begin
                m_next       = next_phase(m_ph, sensor, m_walk);
                m_enter_walk = (m_next == P_WK);
                m_ph         = m_next;
                m_start      = 1'b1;
                q.push_back(mk(m_next));
            end else begin
                m_start = 1'b0;
            end
            if (m_enter_walk) m_walk = 1'b0;
            else if (walk_req) m_walk = 1'b1;
        end
    end

    // Monitor: pops on every entry pulse, checks hold and safety on every cycle.
    always @(negedge clk) begin
        if (rst) begin
            cur = mk(P_MG);
        end else begin
            chk((main_l == R) || (side_l == R), "safety_one_red", {main_l, side_l}, 1);
            chk(start_timer == m_start, "start_timer", start_timer, m_start);
            if (start_timer) begin
                chk(q.size() > 0, "entry_expected", q.size(), 1);
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    chk(main_l == cur.m, "entry_main", main_l, cur.m);
                    chk(side_l == cur.s, "entry_side", side_l, cur.s);
                    chk(walk_l == cur.w, "entry_walk", walk_l, cur.w);
                    chk(value == cur.v, "entry_value", value, cur.v);
                end
                if (walk_l) walk_entries++;
            end else begin
                chk({main_l, side_l, walk_l, value} == {cur.m, cur.s, cur.w, cur.v},
                    "hold_outputs", {main_l, side_l, walk_l, value}, {cur.m, cur.s, cur.w, cur.v});
            end
            chk(dut.walk_reg == m_walk, "walk_reg", dut.walk_reg, m_walk);
        end
    end

    task automatic wait_phase(input int ph, input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            #1;
            if (m_ph == ph && !m_start) found = 1'b1;
        end
        chk(found, nm, found, 1);
    endtask

    task automatic check_reset_values(input string nm);
        chk(main_l == G, {nm, "_main"}, main_l, G);
        chk(side_l == R, {nm, "_side"}, side_l, R);
        chk(walk_l == 1'b0, {nm, "_walk"}, walk_l, 0);
        chk(start_timer == 1'b1, {nm, "_start"}, start_timer, 1);
        chk(value == 4'(T_BASE), {nm, "_value"}, value, T_BASE);
        chk(dut.walk_reg == 1'b0, {nm, "_walk_reg"}, dut.walk_reg, 0);
    endtask

    initial begin
        int w0;
        bit seen;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk(start_timer == 1'b0, "release_start_drop", start_timer, 0);

        // No traffic, no pedestrians: MAIN_G keeps re-entering
        repeat (150) @(negedge clk);

        // Side traffic throughout: full extended cycle
        #1 sensor = 1'b1;
        repeat (300) @(negedge clk);

        // Single walk pulse during MAIN_G
        #1 sensor = 1'b0;
        wait_phase(P_MG, "wait_main_g");
        w0 = walk_entries;
        walk_req = 1'b1;
        @(negedge clk);
        #1 walk_req = 1'b0;
        repeat (250) @(negedge clk);
        chk(walk_entries - w0 == 1, "single_walk_served", walk_entries - w0, 1);

        // Walk held high across WALK entry: cleared on entry, re-set next cycle
        #1 walk_req = 1'b1;
        w0 = walk_entries;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (start_timer && walk_l) seen = 1'b1;
        end
        chk(seen, "walk_entry_seen", seen, 1);
        chk(dut.walk_reg == 1'b0, "walk_reg_cleared_on_entry", dut.walk_reg, 0);
        @(negedge clk);
        chk(dut.walk_reg == 1'b1, "walk_reg_reset_next_cycle", dut.walk_reg, 1);
        repeat (300) @(negedge clk);
        chk(walk_entries - w0 >= 2, "walk_recurs", walk_entries - w0, 2);
        #1 walk_req = 1'b0;

        // Random traffic, button presses and stale expiries during start pulses
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            sensor    = 1'($urandom_range(0, 1));
            walk_req  = ($urandom_range(0, 19) == 0);
            force_exp = start_timer ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        #1 force_exp = 1'b0;
        walk_req = 1'b0;

        // Asynchronous reset in the middle of SIDE_G
        sensor = 1'b1;
        wait_phase(P_SG, "wait_side_g");
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk(start_timer == 1'b0, "mid_release_start_drop", start_timer, 0);

        // Settle and confirm every expected entry was observed
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            sensor   = 1'($urandom_range(0, 1));
            walk_req = ($urandom_range(0, 29) == 0);
        end
        @(negedge clk);
        #1;
        chk(q.size() == 0, "scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
